// File: rtl/cosine_pkg.sv
// Shared types and constants for the cosine Taylor-series controller and datapath.
package cosine_pkg;

  localparam int CNT_W     = 3;
  localparam int TERMS_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_MUL_X, S_MUL_C, S_ACC, S_NEXT, S_FIN
  } state_e;

  typedef struct packed {
    logic ready;
    logic busy;
    logic done;
    logic ldx;
    logic zc;
    logic one_t;
    logic one_r;
    logic mult_1;
    logic mult_2;
    logic ldt;
    logic zarb_done;
    logic ldr;
    logic enc;
  } ctrl_t;

  // Strobe pattern for a state. Registering decode(next_state) keeps every
  // strobe aligned with its state and free of glitches.
  function automatic ctrl_t decode(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_IDLE:  c.ready = 1'b1;
      S_INIT:  begin c.busy = 1'b1; c.ldx = 1'b1; c.zc = 1'b1; c.one_t = 1'b1; c.one_r = 1'b1; end
      S_MUL_X: begin c.busy = 1'b1; c.mult_1 = 1'b1; c.ldt = 1'b1; end
      S_MUL_C: begin c.busy = 1'b1; c.mult_2 = 1'b1; c.ldt = 1'b1; end
      S_ACC:   begin c.busy = 1'b1; c.zarb_done = 1'b1; c.ldr = 1'b1; end
      S_NEXT:  begin c.busy = 1'b1; c.enc = 1'b1; end
      S_FIN:   begin c.busy = 1'b1; c.done = 1'b1; end
      default: c.ready = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cosine_controller_term_counter.sv
// Term index k: cleared in INIT, advanced in NEXT, flags the final term.
module term_counter
  import cosine_pkg::*;
#(
  parameter int TERMS = TERMS_DEF
) (
  input  logic clk,
  input  logic res,
  input  logic clr,
  input  logic inc,
  output logic last
);

  logic [CNT_W-1:0] k_q, k_d;

  assign last = (k_q == CNT_W'(TERMS - 1));

  // Increment is suppressed on the final term so k never passes TERMS-1.
  always_comb begin
    k_d = k_q;
    if (clr)              k_d = '0;
    else if (inc && !last) k_d = k_q + 1'b1;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) k_q <= '0;
    else      k_q <= k_d;
  end

endmodule

// File: rtl/cosine_controller.sv
// Control FSM sequencing the cosine datapath: INIT, (MUL_X, MUL_C, ACC, NEXT) x TERMS, FIN.
module cosine_controller
  import cosine_pkg::*;
#(
  parameter int TERMS = TERMS_DEF
) (
  input  logic clk,
  input  logic res,
  input  logic start,
  input  logic check_less,
  output logic ready,
  output logic busy,
  output logic done,
  output logic less,
  output logic ldx,
  output logic zc,
  output logic one_t,
  output logic one_r,
  output logic mult_1,
  output logic mult_2,
  output logic ldt,
  output logic zarb_done,
  output logic ldr,
  output logic enc
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   less_q, less_d;
  logic   last;

  term_counter #(.TERMS(TERMS)) u_term_counter (
    .clk  (clk),
    .res  (res),
    .clr  (state_q == S_INIT),
    .inc  (state_q == S_NEXT),
    .last (last)
  );

  always_comb begin
    state_d = state_q;
    less_d  = less_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_INIT;
      S_INIT:  state_d = S_MUL_X;
      S_MUL_X: state_d = S_MUL_C;
      S_MUL_C: state_d = S_ACC;
      S_ACC:   state_d = S_NEXT;
      S_NEXT:  state_d = last ? S_FIN : S_MUL_X;
      S_FIN:   begin
        state_d = S_IDLE;
        less_d  = check_less;
      end
      default: state_d = S_IDLE;
    endcase
    ctrl_d = decode(state_d);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= S_IDLE;
      ctrl_q  <= decode(S_IDLE);
      less_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      less_q  <= less_d;
    end
  end

  assign ready     = ctrl_q.ready;
  assign busy      = ctrl_q.busy;
  assign done      = ctrl_q.done;
  assign ldx       = ctrl_q.ldx;
  assign zc        = ctrl_q.zc;
  assign one_t     = ctrl_q.one_t;
  assign one_r     = ctrl_q.one_r;
  assign mult_1    = ctrl_q.mult_1;
  assign mult_2    = ctrl_q.mult_2;
  assign ldt       = ctrl_q.ldt;
  assign zarb_done = ctrl_q.zarb_done;
  assign ldr       = ctrl_q.ldr;
  assign enc       = ctrl_q.enc;
  assign less      = less_q;

endmodule

// File: tb/tb_cosine_controller.sv
// Directed bench for cosine_controller: TERMS=4 instance (a) and TERMS=1 instance (b).
module tb_cosine_controller;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, check_less = 1'b0;

  logic ready_a, busy_a, done_a, less_a, ldx_a, zc_a, one_t_a, one_r_a;
  logic mult_1_a, mult_2_a, ldt_a, zarb_done_a, ldr_a, enc_a;
  logic ready_b, busy_b, done_b, less_b, ldx_b, zc_b, one_t_b, one_r_b;
  logic mult_1_b, mult_2_b, ldt_b, zarb_done_b, ldr_b, enc_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cosine_controller #(.TERMS(4)) dut_a (
    .clk(clk), .res(res), .start(start_a), .check_less(check_less),
    .ready(ready_a), .busy(busy_a), .done(done_a), .less(less_a),
    .ldx(ldx_a), .zc(zc_a), .one_t(one_t_a), .one_r(one_r_a),
    .mult_1(mult_1_a), .mult_2(mult_2_a), .ldt(ldt_a),
    .zarb_done(zarb_done_a), .ldr(ldr_a), .enc(enc_a)
  );

  cosine_controller #(.TERMS(1)) dut_b (
    .clk(clk), .res(res), .start(start_b), .check_less(check_less),
    .ready(ready_b), .busy(busy_b), .done(done_b), .less(less_b),
    .ldx(ldx_b), .zc(zc_b), .one_t(one_t_b), .one_r(one_r_b),
    .mult_1(mult_1_b), .mult_2(mult_2_b), .ldt(ldt_b),
    .zarb_done(zarb_done_b), .ldr(ldr_b), .enc(enc_b)
  );

  // Bit order: ready busy done ldx zc one_t one_r mult_1 mult_2 ldt zarb_done ldr enc
  logic [12:0] vec_a, vec_b;
  assign vec_a = {ready_a, busy_a, done_a, ldx_a, zc_a, one_t_a, one_r_a,
                  mult_1_a, mult_2_a, ldt_a, zarb_done_a, ldr_a, enc_a};
  assign vec_b = {ready_b, busy_b, done_b, ldx_b, zc_b, one_t_b, one_r_b,
                  mult_1_b, mult_2_b, ldt_b, zarb_done_b, ldr_b, enc_b};

  localparam logic [12:0] V_IDLE = 13'b1000000000000;
  localparam logic [12:0] V_INIT = 13'b0101111000000;
  localparam logic [12:0] V_MULX = 13'b0100000101000;
  localparam logic [12:0] V_MULC = 13'b0100000011000;
  localparam logic [12:0] V_ACC  = 13'b0100000000110;
  localparam logic [12:0] V_NEXT = 13'b0100000000001;
  localparam logic [12:0] V_FIN  = 13'b0110000000000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected strobes in cycle n after the start edge (cycle 1 = INIT).
  function automatic logic [12:0] exp_vec(input int n, input int terms);
    if (n == 1) return V_INIT;
    if (n <= 1 + 4*terms) begin
      case ((n - 2) % 4)
        0:       return V_MULX;
        1:       return V_MULC;
        2:       return V_ACC;
        default: return V_NEXT;
      endcase
    end
    if (n == 2 + 4*terms) return V_FIN;
    return V_IDLE;
  endfunction

  // One evaluation on instance a; optionally toggles start while busy.
  task automatic run_a(input bit toggle, input bit seq, output int done_cyc,
                       output int n_done, output int n_enc, output int n_ldt, output int n_ldr);
    done_cyc = -1; n_done = 0; n_enc = 0; n_ldt = 0; n_ldr = 0;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 22; n++) begin
      @(negedge clk);
      start_a = (toggle && n <= 18) ? n[0] : 1'b0;
      if (done_a) begin done_cyc = n; n_done++; end
      if (enc_a) n_enc++;
      if (ldt_a) n_ldt++;
      if (ldr_a) n_ldr++;
      if (seq) chk($sformatf("seq_a[%0d]", n), 32'(vec_a), 32'(exp_vec(n, 4)));
      if (n == 19) chk("less_after_fin", 32'(less_a), 32'(check_less));
    end
  endtask

  initial begin
    int dc, nd, ne, nt, nr;
    int d1, d2;
    bit seen_idle;

    // Reset state
    #1 res = 1'b0;
    #1;
    chk("rst_vec_a", 32'(vec_a), 32'(V_IDLE));
    chk("rst_less_a", 32'(less_a), 32'd0);
    chk("rst_vec_b", 32'(vec_b), 32'(V_IDLE));
    repeat (3) @(negedge clk);
    res = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_rst", 32'(vec_a), 32'(V_IDLE));

    // Single run, TERMS=4, compare flag high in FIN
    check_less = 1'b1;
    run_a(1'b0, 1'b1, dc, nd, ne, nt, nr);
    chk("run1_done_cyc", 32'(dc), 32'd18);
    chk("run1_n_done", 32'(nd), 32'd1);
    chk("run1_enc", 32'(ne), 32'd4);
    chk("run1_ldt", 32'(nt), 32'd8);
    chk("run1_ldr", 32'(nr), 32'd4);
    chk("run1_less_held", 32'(less_a), 32'd1);

    // Reset mid-MUL_C abandons the evaluation and clears less
    @(negedge clk); start_a = 1'b1;
    @(posedge clk);
    @(negedge clk); start_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_mulc", 32'(vec_a), 32'(V_MULC));
    res = 1'b0;
    #1;
    chk("async_rst_vec", 32'(vec_a), 32'(V_IDLE));
    chk("async_rst_less", 32'(less_a), 32'd0);
    @(negedge clk); res = 1'b1;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (vec_a !== V_IDLE) nd++;
    end
    chk("stay_idle_after_rst", 32'(nd), 32'd0);

    // start toggling while busy is ignored; compare flag low this time
    check_less = 1'b0;
    run_a(1'b1, 1'b1, dc, nd, ne, nt, nr);
    chk("tog_done_cyc", 32'(dc), 32'd18);
    chk("tog_n_done", 32'(nd), 32'd1);
    chk("tog_less", 32'(less_a), 32'd0);

    // Back-to-back with start held high
    d1 = -1; d2 = -1;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (done_a) begin
        if (d1 < 0) d1 = n;
        else if (d2 < 0) d2 = n;
      end
    end
    start_a = 1'b0;
    chk("b2b_first", 32'(d1), 32'd18);
    chk("b2b_spacing", 32'(d2 - d1), 32'd19);
    seen_idle = 1'b0;
    for (int i = 0; i < 25 && !seen_idle; i++) begin
      @(negedge clk);
      if (ready_a) seen_idle = 1'b1;
    end
    chk("b2b_returns_idle", 32'(seen_idle), 32'd1);

    // TERMS=1 instance
    dc = -1; ne = 0; nr = 0;
    @(negedge clk); start_b = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (done_b) dc = n;
      if (enc_b) ne++;
      if (ldr_b) nr++;
      chk($sformatf("seq_b[%0d]", n), 32'(vec_b), 32'(exp_vec(n, 1)));
    end
    chk("t1_done_cyc", 32'(dc), 32'd6);
    chk("t1_enc", 32'(ne), 32'd1);
    chk("t1_ldr", 32'(nr), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cosine_controller.md
# cosine_controller

Control FSM that sequences the cosine Taylor-series datapath. It accepts a start request, drives every load, select and count strobe of the datapath for a fixed number of series terms, and reports completion. It also latches the datapath's threshold-compare flag. It sits directly upstream of the datapath, and its outputs connect one-to-one to the datapath control inputs.

## Interface
Parameters:
- TERMS, 4, number of series terms after the constant 1; legal range 1..7 (3-bit ROM address).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- res  in  1  reset, asynchronous, active-low.
- start  in  1  request one evaluation; sampled only in IDLE.
- check_less  in  1  datapath comparator output (y < result).
- ready  out  1  high in IDLE; start accepted only when high.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse when the result is final.
- less  out  1  check_less captured at done; held until the next done or reset.
- ldx, zc, one_t, one_r  out  1 each  initialisation strobes to the datapath.
- mult_1, mult_2, ldt  out  1 each  multiplier operand select (x² / coefficient) and temp register load.
- zarb_done, ldr  out  1 each  accumulate the term into the result register.
- enc  out  1  advance the datapath coefficient counter.

## Operation
- States: IDLE, INIT, MUL_X, MUL_C, ACC, NEXT, FIN.
- IDLE: ready=1. start=1 → INIT. Otherwise stay in IDLE.
- INIT, 1 cycle: ldx=1, zc=1, one_t=1, one_r=1. This loads x², clears the coefficient counter, and sets temp=1 and result=1. It also clears the internal term index k to 0. → MUL_X.
- MUL_X: mult_1=1, ldt=1, so temp ← temp·x². → MUL_C.
- MUL_C: mult_2=1, ldt=1, so temp ← temp·ROM[k]. → ACC.
- ACC: zarb_done=1, ldr=1, so result ← result ± temp. The sign follows counter parity inside the datapath. → NEXT.
- NEXT: enc=1. If k == TERMS-1 → FIN. Otherwise k ← k+1 → MUL_X.
- FIN: done=1, less ← check_less. → IDLE.
- Every strobe not listed for a state is 0 in that state.
- mult_1 and mult_2 are never high together.
- ldt is never high in the same cycle as one_t.
- k is 3 bits wide. k never exceeds TERMS-1, so it never wraps.
- Every strobe is a registered output, decoded from the current state and free of glitches.

## Timing
- On reset assertion, immediately and asynchronously:
  - state = IDLE, k = 0.
  - ready = 1.
  - busy, done and less = 0.
  - All datapath strobes = 0.
- Reset mid-evaluation abandons the evaluation. No done pulse is produced.
- Latency: start sampled high at edge E0 puts the FSM in INIT during the cycle after E0. done is high during cycle 2+4·TERMS after E0, which is cycle 18 for TERMS=4.
- Throughput: a new start may be accepted on the edge that ends FIN's IDLE cycle. That gives a minimum start-to-start spacing of 3+4·TERMS cycles.
- start high while busy is ignored. It is neither queued nor does it restart the evaluation.
- start held high continuously causes back-to-back evaluations with one IDLE cycle between them.
- The x input of the datapath must be stable during INIT. It is don't-care in all other cycles.
- less is sampled from check_less in FIN, after the final ldr has settled.

## Structure
- Shared package cosine_pkg holds:
  - the state enum;
  - the CNT_W=3 constant;
  - the TERMS default.
- The datapath also imports CNT_W from cosine_pkg.
- One sub-module: term_counter.
  - Behaviour: 3-bit up-counter with clear, increment, and terminal flag (k == TERMS-1).
  - Instantiation: inside the FSM.
- The top level that pairs cosine_controller with the datapath is outside this block.

## Test plan
- Reset: assert res=0 mid-MUL_C → ready=1, busy=0, done=0, less=0 and all strobes 0 within the same cycle. After release, the FSM stays in IDLE until start.
- Single run, TERMS=4, start pulse at E0 → strobe sequence matches state for state:
  - INIT;
  - then (MUL_X, MUL_C, ACC, NEXT)×4;
  - then FIN.
  - done high exactly in cycle 18 after E0, enc pulsed 4 times, ldt 8 times, ldr 4 times.
- Ignored start: toggle start every cycle while busy → exactly one done pulse, still at cycle 18.
- Back-to-back: hold start=1 → done pulses 19 cycles apart.
- TERMS=1 → done in cycle 6 after E0, with one enc and one ACC.
- Compare capture, with the datapath model:
  - check_less=1 in FIN → less=1, held through the following IDLE.
  - check_less=0 on the next run → less=0.
